tl_bypass_sequencer: RTL and testbench
======================================

// Module: tl_bypass_sequencer
// PURPOSE
//  Sequences the io_bypass select of the TileLink bus-bypass crossbar so it only changes while no transaction is in flight.
//  Sits beside the bypass wrapper on its inner (node_in) port.
//  Accepts bypass-change requests from a control register, gates new A beats, drains outstanding D responses, flips bypass, then acks.
//  Bounded by a drain timeout so a hung target cannot stall the requester forever.
// PARAMETERS
//  MAX_INFLIGHT    4     max outstanding A without D; counter width = $clog2(MAX_INFLIGHT+1)
//  TIMEOUT_CYCLES  1024  drain cycles before abort; 0 = no timeout
//  SETTLE_CYCLES   1     cycles gate held after bypass flips (>=1)
//  RESET_BYPASS    1'b1  bypass value out of reset (error device selected)
// PORTS
//  clock          in   1  sole clock
//  reset          in   1  synchronous, active-high
//  req_valid      in   1  bypass-change request
//  req_bypass     in   1  requested bypass value
//  req_ready      out  1  high only in IDLE
//  a_valid        in   1  node_in A valid (ungated, from master)
//  a_ready        in   1  node_in A ready (ungated, from bar)
//  d_valid        in   1  node_in D valid
//  d_ready        in   1  node_in D ready
//  gate_a         out  1  wrapper forces master-side a_ready=0 and bar-side a_valid=0 while high
//  io_bypass      out  1  registered bypass select to the bar
//  done           out  1  one-cycle pulse at request completion
//  done_err       out  1  qualifies done: 1 = aborted by timeout, bypass unchanged
//  proto_err      out  1  sticky: D beat seen with zero in flight; cleared only by reset
//  inflight       out  W  current outstanding count
// BEHAVIOUR
//  Reset values: io_bypass=RESET_BYPASS, gate_a=0, req_ready=1, done=0, done_err=0, proto_err=0, inflight=0, state=IDLE.
//  Single-beat TL-UL only: a_fire = a_valid & a_ready & ~gate_a; d_fire = d_valid & d_ready.
//  Counter:
//   - +1 on a_fire only; -1 on d_fire only; unchanged on both.
//   - d_fire at 0: stays 0, sets proto_err.
//   - gate_a is also forced high whenever inflight==MAX_INFLIGHT (flow control); count never exceeds MAX_INFLIGHT.
//  FSM IDLE -> DRAIN -> SETTLE -> DONE -> IDLE:
//   - IDLE: req_ready=1.
//     - On req_valid & req_bypass==io_bypass: go to DONE (no gating); done pulses next cycle.
//     - On req_valid & req_bypass!=io_bypass: go to DRAIN; gate_a=1 from next cycle.
//       The accept cycle's a_fire still counts.
//   - DRAIN: gate_a=1, timeout counter runs.
//     - When inflight==0 and no d_fire this cycle: flip io_bypass (visible next cycle), go to SETTLE.
//     - When timeout counter reaches TIMEOUT_CYCLES-1 first: go to DONE with done_err=1; io_bypass unchanged.
//     - Drain completion wins if both occur in the same cycle.
//   - SETTLE: gate_a=1 for SETTLE_CYCLES, then DONE.
//   - DONE: done=1 (with done_err) for one cycle; gate_a=0 unless the count is full; return to IDLE.
//  Latency: matched request -> done in 2 cycles.
//   Mismatched request with inflight=0 -> done in 3+SETTLE_CYCLES cycles.
//  req_valid outside IDLE is ignored (req_ready=0); the requester holds it.
//  Reset mid-drain: all state returns to reset values; the in-flight count is discarded.
//   Reset is system-wide, so the crossbar is also cleared.
// STRUCTURE
//  tl_bypass_pkg: state_e {IDLE,DRAIN,SETTLE,DONE}, count-width function, TIMEOUT width localparam.
//  Sub-module tl_inflight_counter (param MAX, ports inc/dec/count/full/underflow_err).
//  The FSM and timeout counter live in the top module.
// TESTING
//  1 Reset, then req(bypass=1) while io_bypass=1 -> done at cycle +2, done_err=0, gate_a never high.
//  2 Two A fires without D, then req(bypass=0) -> gate_a high; return 2 D beats -> io_bypass=0 one cycle after last D; done follows SETTLE.
//  3 MAX_INFLIGHT=4; issue 4 A without D -> gate_a=1 and a_valid stays blocked; one D -> gate_a drops next cycle.
//  4 TIMEOUT_CYCLES=8, one A never answered, req(bypass=0) -> done=1 & done_err=1 at drain cycle 8; io_bypass stays 1.
//  5 Same-cycle a_fire and d_fire at inflight=1 -> stays 1; d_fire at inflight=0 -> proto_err=1 and stays set.
//  6 Assert reset during DRAIN with inflight=3 -> next cycle all outputs at reset values, req_ready=1.

Source files
------------

// File: rtl/tl_bypass_pkg.sv
// Shared types for the TileLink bypass sequencer.
// FSM state encoding, counter width helper, timeout counter width.
package tl_bypass_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SETTLE,
    DONE
  } state_e;

  // Timeout counter width; covers TIMEOUT_CYCLES up to 65536.
  localparam int TO_W = 16;

  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/tl_inflight_counter.sv
// Outstanding single-beat A request counter, saturating at MAX.
// Ports: clock, reset, inc, dec -> count, full, underflow_err.
module tl_inflight_counter
  import tl_bypass_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W = cnt_w(MAX)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         underflow_err
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign full  = (count_q == W'(MAX));
  assign count = count_q;

  // A response with nothing outstanding is a protocol violation.
  assign underflow_err = dec & ~inc & (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (inc & ~dec & ~full) begin
      count_d = count_q + 1'b1;
    end else if (dec & ~inc & (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tl_bypass_sequencer.sv
// Changes the bypass select only when no TL-UL transaction is in flight.
// Ports: req_*, a_*/d_* handshakes in; gate_a, io_bypass, done*, inflight out.
module tl_bypass_sequencer
  import tl_bypass_pkg::*;
#(
  parameter int   MAX_INFLIGHT   = 4,
  parameter int   TIMEOUT_CYCLES = 1024,
  parameter int   SETTLE_CYCLES  = 1,
  parameter logic RESET_BYPASS   = 1'b1,
  localparam int  W = cnt_w(MAX_INFLIGHT)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_bypass,
  output logic         req_ready,
  input  logic         a_valid,
  input  logic         a_ready,
  input  logic         d_valid,
  input  logic         d_ready,
  output logic         gate_a,
  output logic         io_bypass,
  output logic         done,
  output logic         done_err,
  output logic         proto_err,
  output logic [W-1:0] inflight
);

  localparam int SW = cnt_w(SETTLE_CYCLES);

  state_e        state_q, state_d;
  logic          bypass_q, bypass_d;
  logic          err_q, err_d;
  logic          perr_q;
  logic [TO_W-1:0] to_q, to_d;
  logic [SW-1:0] settle_q, settle_d;

  logic a_fire;
  logic d_fire;
  logic full;
  logic underflow;
  logic busy;

  // Gate while sequencing, and also as flow control at the count ceiling.
  assign busy   = (state_q == DRAIN) | (state_q == SETTLE);
  assign gate_a = busy | full;
  assign a_fire = a_valid & a_ready & ~gate_a;
  assign d_fire = d_valid & d_ready;

  tl_inflight_counter #(
    .MAX (MAX_INFLIGHT)
  ) u_cnt (
    .clock         (clock),
    .reset         (reset),
    .inc           (a_fire),
    .dec           (d_fire),
    .count         (inflight),
    .full          (full),
    .underflow_err (underflow)
  );

  assign io_bypass = bypass_q;
  assign req_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign done_err  = (state_q == DONE) & err_q;
  assign proto_err = perr_q;

  always_comb begin
    state_d  = state_q;
    bypass_d = bypass_q;
    err_d    = err_q;
    to_d     = to_q;
    settle_d = settle_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          err_d = 1'b0;
          if (req_bypass == bypass_q) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
            to_d    = '0;
          end
        end
      end
      DRAIN: begin
        // Drain completion takes priority over timeout.
        if ((inflight == '0) & ~d_fire) begin
          bypass_d = ~bypass_q;
          settle_d = '0;
          state_d  = SETTLE;
        end else if ((TIMEOUT_CYCLES != 0) &&
                     (to_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      bypass_q <= RESET_BYPASS;
      err_q    <= 1'b0;
      perr_q   <= 1'b0;
      to_q     <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      bypass_q <= bypass_d;
      err_q    <= err_d;
      perr_q   <= perr_q | underflow;
      to_q     <= to_d;
      settle_q <= settle_d;
    end
  end

endmodule

// File: tb/tb_tl_bypass_sequencer.sv
// Directed and random checks of tl_bypass_sequencer against an
// event-level model of in-flight count and bypass request handling.
module tb_tl_bypass_sequencer;

  localparam int MAX = 4;
  localparam int TO  = 8;
  localparam int ST  = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_bypass = 1'b0;
  logic       req_ready;
  logic       a_valid = 1'b0;
  logic       a_ready = 1'b0;
  logic       d_valid = 1'b0;
  logic       d_ready = 1'b0;
  logic       gate_a;
  logic       io_bypass;
  logic       done;
  logic       done_err;
  logic       proto_err;
  logic [2:0] inflight;

  int tests = 0;
  int fails = 0;

  // Model state: outstanding count, bypass, sticky error, and request
  // progress as drain-cycle index / settle cycles left / done pending.
  int m_cnt;
  bit m_byp;
  bit m_perr;
  int m_drain;
  int m_settle;
  bit m_done;
  bit m_err;

  always #5 clock = ~clock;

  tl_bypass_sequencer #(
    .MAX_INFLIGHT   (MAX),
    .TIMEOUT_CYCLES (TO),
    .SETTLE_CYCLES  (ST),
    .RESET_BYPASS   (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_bypass (req_bypass),
    .req_ready  (req_ready),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .gate_a     (gate_a),
    .io_bypass  (io_bypass),
    .done       (done),
    .done_err   (done_err),
    .proto_err  (proto_err),
    .inflight   (inflight)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    return (m_drain >= 0) || (m_settle > 0);
  endfunction

  task automatic model_next();
    bit gate, af, df;
    int nc;
    if (reset) begin
      m_cnt = 0; m_byp = 1'b1; m_perr = 1'b0;
      m_drain = -1; m_settle = 0; m_done = 1'b0; m_err = 1'b0;
      return;
    end
    gate = m_busy() || (m_cnt == MAX);
    af = a_valid && a_ready && !gate;
    df = d_valid && d_ready;
    nc = m_cnt;
    if (af && !df) nc = m_cnt + 1;
    else if (df && !af) begin
      if (m_cnt > 0) nc = m_cnt - 1;
      else m_perr = 1'b1;
    end
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_drain >= 0) begin
      if (m_cnt == 0 && !df) begin
        m_byp = !m_byp;
        m_drain = -1;
        m_settle = ST;
      end else if (m_drain == TO - 1) begin
        m_drain = -1;
        m_done = 1'b1;
        m_err = 1'b1;
      end else begin
        m_drain++;
      end
    end else if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) begin
        m_done = 1'b1;
        m_err = 1'b0;
      end
    end else if (req_valid) begin
      if (req_bypass == m_byp) begin
        m_done = 1'b1;
        m_err = 1'b0;
      end else begin
        m_drain = 0;
      end
    end
    m_cnt = nc;
  endtask

  task automatic check_all();
    chk("inflight", 32'(inflight), 32'(m_cnt));
    chk("gate_a", 32'(gate_a), 32'(m_busy() || m_cnt == MAX));
    chk("io_bypass", 32'(io_bypass), 32'(m_byp));
    chk("req_ready", 32'(req_ready), 32'(!m_busy() && !m_done));
    chk("done", 32'(done), 32'(m_done));
    chk("done_err", 32'(done_err), 32'(m_done && m_err));
    chk("proto_err", 32'(proto_err), 32'(m_perr));
  endtask

  task automatic step(input bit av, input bit ar, input bit dv,
                      input bit dr, input bit rv, input bit rb);
    a_valid = av; a_ready = ar;
    d_valid = dv; d_ready = dr;
    req_valid = rv; req_bypass = rb;
    model_next();
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clock);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("rst_bypass", 32'(io_bypass), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // 1: matched request completes without gating
    step(0, 0, 0, 0, 1, 1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_gate", 32'(gate_a), 32'd0);
    idle(1);

    // 2: drain two outstanding beats, then flip to 0
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t2_gate", 32'(gate_a), 32'd1);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("t2_hold", 32'(io_bypass), 32'd1);
    idle(1);
    chk("t2_flip", 32'(io_bypass), 32'd0);
    idle(1);
    chk("t2_done", 32'(done), 32'd1);
    idle(1);

    // 3: flow control at the ceiling
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
    chk("t3_full", 32'(gate_a), 32'd1);
    step(1, 1, 0, 0, 0, 0);
    chk("t3_blocked", 32'(inflight), 32'd4);
    step(1, 1, 1, 1, 0, 0);
    chk("t3_open", 32'(gate_a), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0);

    // restore bypass=1 with nothing in flight
    step(0, 0, 0, 0, 1, 1);
    idle(4);
    chk("t4_pre", 32'(io_bypass), 32'd1);

    // 4: drain timeout with one unanswered request
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(7);
    chk("t4_wait", 32'(done), 32'd0);
    idle(1);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_err", 32'(done_err), 32'd1);
    chk("t4_byp", 32'(io_bypass), 32'd1);
    idle(1);

    // 5: simultaneous fires hold count; underflow is sticky
    step(1, 1, 1, 1, 0, 0);
    chk("t5_same", 32'(inflight), 32'd1);
    step(0, 0, 1, 1, 0, 0);
    chk("t5_noerr", 32'(proto_err), 32'd0);
    step(0, 0, 1, 1, 0, 0);
    chk("t5_perr", 32'(proto_err), 32'd1);
    idle(3);
    chk("t5_sticky", 32'(proto_err), 32'd1);

    // 6: reset in the middle of a drain
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(1);
    chk("t6_pre", 32'(inflight), 32'd3);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("t6_cnt", 32'(inflight), 32'd0);
    chk("t6_ready", 32'(req_ready), 32'd1);
    chk("t6_perr", 32'(proto_err), 32'd0);
    chk("t6_gate", 32'(gate_a), 32'd0);

    // random traffic and requests
    for (int i = 0; i < 600; i++) begin
      bit dv;
      dv = (m_cnt > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           dv, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
